// File: rtl/onehot_pulse_decoder.sv
// ============================================================================
// onehot_pulse_decoder
// ----------------------------------------------------------------------------
// Sequential binary-to-one-hot decoder. An encoded line index is accepted over
// a valid/ready handshake. The matching one-hot line is then driven high for
// PULSE_LEN cycles, followed by GAP_LEN all-zero cycles, before the block
// returns to IDLE and can accept the next request. An index that does not name
// an existing line is consumed and reported on dec_err; no pulse is produced.
//
// Parameters
//   IDX_W      width of the encoded index input
//   N          number of one-hot output lines (2 <= N <= 2**IDX_W)
//   PULSE_LEN  cycles the selected line is held high (>= 1)
//   GAP_LEN    all-zero cycles after each pulse (>= 0)
//
// Ports
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous, active-high reset
//   dec_in_valid  in   1      dec_in holds a request
//   dec_in_ready  out  1      block can accept a request this cycle
//   dec_in        in   IDX_W  encoded line index
//   dec_out       out  N      one-hot strobe lines (registered)
//   dec_busy      out  1      high while in DRIVE or GAP
//   dec_err       out  1      one-cycle pulse: out-of-range index accepted
// ============================================================================
module onehot_pulse_decoder #(
    parameter int IDX_W     = 2,
    parameter int N         = 4,
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_in_valid,
    output logic             dec_in_ready,
    input  logic [IDX_W-1:0] dec_in,
    output logic [N-1:0]     dec_out,
    output logic             dec_busy,
    output logic             dec_err
);

    // The counter only ever holds a pulse or gap length minus one, so it is
    // sized for the larger of the two.
    localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               HAS_GAP    = (GAP_LEN > 0);

    localparam logic [N-1:0] LINE0 = N'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [N-1:0]     out_next;
    logic             err_next;
    logic             idx_ok;

    // When every encodable index names a real line there is nothing to range
    // check, so dec_err can never fire and the comparator disappears.
    generate
        if (N < (1 << IDX_W)) begin : g_range_check
            localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);
            assign idx_ok = ({1'b0, dec_in} < N_EXT);
        end else begin : g_full_range
            assign idx_ok = 1'b1;
        end
    endgenerate

    // State register. The strobe lines and the error flag are registered here
    // too, so an asserted reset clears every output-facing flop at once, even
    // in the middle of a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dec_out <= '0;
            dec_err <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            dec_out <= out_next;
            dec_err <= err_next;
        end
    end

    // Next-state logic. The counter is loaded on entry to DRIVE or GAP and
    // counts down to zero; zero marks the last cycle of that phase, so it
    // never has to wrap. dec_in is looked at only in IDLE with valid high,
    // which is exactly a transfer because ready equals (state == IDLE).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = dec_out;
        err_next   = 1'b0;

        case (state)
            IDLE: begin
                out_next = '0;
                if (dec_in_valid) begin
                    if (idx_ok) begin
                        state_next = DRIVE;
                        out_next   = LINE0 << dec_in;
                        cnt_next   = PULSE_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            DRIVE: begin
                if (cnt == '0) begin
                    out_next = '0;
                    if (HAS_GAP) begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            GAP: begin
                out_next = '0;
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                out_next   = '0;
            end
        endcase
    end

    // Output decode. Ready is gated by rst so that no transfer can appear to
    // be offered while the block is being held in reset.
    always_comb begin
        dec_in_ready = (state == IDLE) && !rst;
        dec_busy     = (state == DRIVE) || (state == GAP);
    end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// ============================================================================
// tb_onehot_pulse_decoder
// ----------------------------------------------------------------------------
// Directed bench for onehot_pulse_decoder. Three instances share clock and
// reset:
//   dut0  defaults            (IDX_W=2, N=4, PULSE_LEN=3, GAP_LEN=1)
//   dut1  three lines         (N=3) for the out-of-range index path
//   dut2  shortest timing     (PULSE_LEN=1, GAP_LEN=0)
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at that same point, so a value seen after edge k is the one the DUT
// presents at edge k+1.
// ============================================================================
module tb_onehot_pulse_decoder;

    logic       clk;
    logic       rst;

    logic       valid0, valid1, valid2;
    logic [1:0] in0, in1, in2;
    logic       ready0, ready1, ready2;
    logic [3:0] out0;
    logic [2:0] out1;
    logic [3:0] out2;
    logic       busy0, busy1, busy2;
    logic       err0, err1, err2;

    int checkCount;
    int failCount;

    onehot_pulse_decoder #(.IDX_W(2), .N(4), .PULSE_LEN(3), .GAP_LEN(1)) dut0 (
        .clk(clk), .rst(rst), .dec_in_valid(valid0), .dec_in_ready(ready0),
        .dec_in(in0), .dec_out(out0), .dec_busy(busy0), .dec_err(err0)
    );

    onehot_pulse_decoder #(.IDX_W(2), .N(3), .PULSE_LEN(3), .GAP_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .dec_in_valid(valid1), .dec_in_ready(ready1),
        .dec_in(in1), .dec_out(out1), .dec_busy(busy1), .dec_err(err1)
    );

    onehot_pulse_decoder #(.IDX_W(2), .N(4), .PULSE_LEN(1), .GAP_LEN(0)) dut2 (
        .clk(clk), .rst(rst), .dec_in_valid(valid2), .dec_in_ready(ready2),
        .dec_in(in2), .dec_out(out2), .dec_busy(busy2), .dec_err(err2)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the request inputs of one of the three instances.
    task automatic applyStimulus(input int unit, input logic v, input logic [1:0] idx);
        case (unit)
            0: begin valid0 = v; in0 = idx; end
            1: begin valid1 = v; in1 = idx; end
            default: begin valid2 = v; in2 = idx; end
        endcase
    endtask

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        applyStimulus(0, 1'b0, 2'd0);
        applyStimulus(1, 1'b0, 2'd0);
        applyStimulus(2, 1'b0, 2'd0);

        // ---------------- reset state ----------------
        #1;
        checkOutput("rst_out0",   32'(out0),   32'h0);
        checkOutput("rst_busy0",  32'(busy0),  32'h0);
        checkOutput("rst_err0",   32'(err0),   32'h0);
        checkOutput("rst_ready0", 32'(ready0), 32'h0);
        checkOutput("rst_ready1", 32'(ready1), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rel_ready0", 32'(ready0), 32'h1);
        checkOutput("rel_ready1", 32'(ready1), 32'h1);
        checkOutput("rel_ready2", 32'(ready2), 32'h1);

        // ---------------- single request, dec_in=2 ----------------
        $display("[TB] single request");
        applyStimulus(0, 1'b1, 2'd2);
        tick();                                   // transfer edge k
        applyStimulus(0, 1'b0, 2'd0);
        checkOutput("single_k1_out",   32'(out0),   32'h4);
        checkOutput("single_k1_busy",  32'(busy0),  32'h1);
        checkOutput("single_k1_ready", 32'(ready0), 32'h0);
        tick();
        checkOutput("single_k2_out", 32'(out0), 32'h4);
        tick();
        checkOutput("single_k3_out", 32'(out0), 32'h4);
        tick();
        checkOutput("single_gap_out",   32'(out0),   32'h0);
        checkOutput("single_gap_busy",  32'(busy0),  32'h1);
        checkOutput("single_gap_ready", 32'(ready0), 32'h0);
        tick();
        checkOutput("single_idle_ready", 32'(ready0), 32'h1);
        checkOutput("single_idle_busy",  32'(busy0),  32'h0);
        checkOutput("single_idle_out",   32'(out0),   32'h0);
        checkOutput("single_err",        32'(err0),   32'h0);

        // ------- back-to-back with data changing while busy -------
        // Valid stays high. dec_in wanders during the first pulse; only the
        // value present at the second transfer edge (0) may be decoded.
        $display("[TB] back-to-back");
        applyStimulus(0, 1'b1, 2'd3);
        tick();                                   // transfer of 3
        applyStimulus(0, 1'b1, 2'd1);
        checkOutput("b2b_p1_c1", 32'(out0), 32'h8);
        tick();
        applyStimulus(0, 1'b1, 2'd2);
        checkOutput("b2b_p1_c2", 32'(out0), 32'h8);
        tick();
        checkOutput("b2b_p1_c3", 32'(out0), 32'h8);
        tick();
        checkOutput("b2b_zero1_out",   32'(out0),   32'h0);
        checkOutput("b2b_zero1_ready", 32'(ready0), 32'h0);
        tick();
        checkOutput("b2b_zero2_out",   32'(out0),   32'h0);
        checkOutput("b2b_zero2_ready", 32'(ready0), 32'h1);
        applyStimulus(0, 1'b1, 2'd0);
        tick();                                   // transfer of 0
        applyStimulus(0, 1'b0, 2'd3);
        checkOutput("b2b_p2_c1", 32'(out0), 32'h1);
        tick();
        checkOutput("b2b_p2_c2", 32'(out0), 32'h1);
        tick();
        checkOutput("b2b_p2_c3", 32'(out0), 32'h1);
        tick();
        checkOutput("b2b_p2_end", 32'(out0), 32'h0);
        tick();
        checkOutput("b2b_idle_ready", 32'(ready0), 32'h1);
        tick();
        checkOutput("b2b_no_retrigger", 32'(busy0), 32'h0);

        // ---------------- reset mid-DRIVE ----------------
        $display("[TB] reset mid-pulse");
        applyStimulus(0, 1'b1, 2'd1);
        tick();
        applyStimulus(0, 1'b0, 2'd0);
        checkOutput("midrst_pre_out", 32'(out0), 32'h2);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out",   32'(out0),   32'h0);
        checkOutput("midrst_busy",  32'(busy0),  32'h0);
        checkOutput("midrst_err",   32'(err0),   32'h0);
        checkOutput("midrst_ready", 32'(ready0), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("midrst_rel_ready", 32'(ready0), 32'h1);
        tick();
        checkOutput("midrst_no_resume_out",  32'(out0),  32'h0);
        checkOutput("midrst_no_resume_busy", 32'(busy0), 32'h0);

        // ---------------- N=3 out-of-range index ----------------
        $display("[TB] out-of-range index");
        applyStimulus(1, 1'b1, 2'd3);
        tick();
        applyStimulus(1, 1'b1, 2'd1);
        checkOutput("oor_err",   32'(err1),   32'h1);
        checkOutput("oor_out",   32'(out1),   32'h0);
        checkOutput("oor_ready", 32'(ready1), 32'h1);
        checkOutput("oor_busy",  32'(busy1),  32'h0);
        tick();                                   // transfer of 1
        applyStimulus(1, 1'b0, 2'd0);
        checkOutput("oor_err_once", 32'(err1), 32'h0);
        checkOutput("n3_c1",        32'(out1), 32'h2);
        tick();
        checkOutput("n3_c2", 32'(out1), 32'h2);
        tick();
        checkOutput("n3_c3", 32'(out1), 32'h2);
        tick();
        checkOutput("n3_gap", 32'(out1), 32'h0);

        // ------------- PULSE_LEN=1, GAP_LEN=0, continuous valid -------------
        $display("[TB] minimum pulse and gap");
        applyStimulus(2, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();                               // transfer of index i
            applyStimulus(2, 1'b1, 2'((i + 1) % 4));
            checkOutput("min_pulse_out",  32'(out2),  32'(1 << i));
            checkOutput("min_pulse_busy", 32'(busy2), 32'h1);
            tick();
            checkOutput("min_idle_out",   32'(out2),   32'h0);
            checkOutput("min_idle_busy",  32'(busy2),  32'h0);
            checkOutput("min_idle_ready", 32'(ready2), 32'h1);
        end
        applyStimulus(2, 1'b0, 2'd0);
        checkOutput("min_err", 32'(err2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
